instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Owns the program counter; fetches instructions from instruction memory over a req/ack handshake.
//  Presents the captured instruction to the decode stage: Instr[31:26] -> Op, Instr[5:0] -> funct.
//  Consumes PCSrc and Jump from the control unit to form the next PC.
//  Instr_valid qualifies the execute cycle: the datapath gates RegWrite/MemWrite with it.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; bits [1:0] forced to 0
//  MAX_WAIT   15             max cycles imem_req may stay high without imem_ack before a fetch error (>=1)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  PCSrc        in   1   branch taken (Branch & Zero), sampled in EXEC only
//  Jump         in   1   jump instruction, sampled in EXEC only
//  SignImm      in   32  sign-extended Instr[15:0], sampled in EXEC only
//  imem_ack     in   1   instruction memory: imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word
//  imem_req     out  1   fetch request, held high until ack
//  imem_addr    out  32  fetch address (= PC)
//  Instr        out  32  registered current instruction
//  Instr_valid  out  1   high exactly one cycle per instruction (EXEC state)
//  PC           out  32  current PC
//  PCPlus4      out  32  PC + 4, combinational
//  fetch_err    out  1   sticky fetch timeout flag
// BEHAVIOUR
//  Reset (rst high at a clock edge, from any state):
//   - PC=RESET_PC & ~32'h3, Instr=0, state=IDLE, wait counter=0, fetch_err=0.
//   - imem_req=0 and Instr_valid=0 in the following cycle.
//   - imem_ack is ignored in any cycle where rst is high.
//  FSM: IDLE, FETCH, EXEC, ERROR.
//  IDLE: outputs quiet; next cycle -> FETCH.
//  FETCH:
//   - imem_req=1, imem_addr=PC; wait counter increments each cycle without ack.
//   - On imem_ack: Instr<=imem_rdata, counter<=0, -> EXEC.
//   - Ack in the first FETCH cycle is legal; minimum latency is FETCH(1) + EXEC(1) = 2 cycles per instruction.
//   - If the counter reaches MAX_WAIT with no ack: -> ERROR.
//  EXEC:
//   - Instr_valid=1, imem_req=0; control unit decodes Instr combinationally.
//   - At the clock edge, PC <= next_pc, then -> FETCH.
//   - Any imem_ack in EXEC is ignored.
//  ERROR:
//   - fetch_err=1, imem_req=0, Instr_valid=0; PC and Instr frozen.
//   - Leaves only via rst.
//  next_pc (32-bit, wrap modulo 2^32, no overflow flag):
//   - Jump=1: {PCPlus4[31:28], Instr[25:0], 2'b00}. Jump has priority over PCSrc.
//   - else PCSrc=1: PCPlus4 + (SignImm << 2).
//   - else: PCPlus4.
//  PC[1:0] is always 0. PC=32'hFFFF_FFFC wraps to 0 with no special handling.
//  PCSrc/Jump/SignImm are don't-care outside EXEC.
// TESTING
//  1. rst high 2 cycles, then low -> PC=RESET_PC, Instr=0, imem_req=0 in IDLE, imem_req=1 the next cycle, imem_addr=0.
//  2. Ack latency 0 then 3, no branch -> PC advances 0 -> 4 -> 8; Instr_valid one cycle each; instruction periods 2 and 5 cycles.
//  3. PC=0x10, EXEC with PCSrc=1, SignImm=0x3 -> next PC=0x20; SignImm=0xFFFF_FFFF -> next PC=0x10.
//  4. PC=0x1000_0004, Instr=0x0800_0040, Jump=1, PCSrc=1 -> next PC=0x1000_0100 (jump wins).
//  5. MAX_WAIT=4, no ack -> ERROR after 4 FETCH cycles; fetch_err=1, req=0; a later ack changes nothing; rst clears everything.
//  6. rst asserted in FETCH with ack in the same cycle -> Instr stays 0, PC=RESET_PC, no Instr_valid pulse.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake and forms the next PC
// from branch/jump controls during the single EXEC cycle of each instruction.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic [31:0] SignImm,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] Instr,
  output logic        Instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        fetch_err
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);
  localparam logic [31:0] PcInit = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StError} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pc_plus4;
  logic [31:0]     next_pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          state_d = StExec;
        end else if (cnt_q == CntLast) begin
          state_d = StError;
        end
      end
      StExec:  state_d = StFetch;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req    = 1'b0;
    Instr_valid = 1'b0;
    fetch_err   = 1'b0;
    unique case (state_q)
      StFetch: imem_req    = 1'b1;
      StExec:  Instr_valid = 1'b1;
      StError: fetch_err   = 1'b1;
      default: ;
    endcase
  end

  // Next-PC selection; jump takes priority over a taken branch
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    if (Jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (PCSrc) begin
      next_pc = pc_plus4 + (SignImm << 2);
    end else begin
      next_pc = pc_plus4;
    end
  end

  // Datapath register next-state
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec:  pc_d = next_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PcInit;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC        = pc_q;
  assign PCPlus4   = pc_plus4;
  assign imem_addr = pc_q;
  assign Instr     = instr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table of instructions with hand-derived PCs, a scoreboard of
// fetched words, and directed reset / timeout sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrc = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] SignImm = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0003),
    .MAX_WAIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc      (PCSrc),
    .Jump       (Jump),
    .SignImm    (SignImm),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .Instr      (Instr),
    .Instr_valid(Instr_valid),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned lat;
    logic [31:0] instr;
    logic        pcsrc;
    logic        jump;
    logic [31:0] simm;
    logic [31:0] pc;
    logic [31:0] next_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t vecs[15];
  sb_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the edge that put the DUT in FETCH
  task automatic run_instr(input int idx, input vec_t v);
    sb_t e;
    PCSrc   = 1'b1;
    Jump    = 1'b1;
    SignImm = 32'h7777_7777;
    for (int w = 0; w < int'(v.lat); w++) begin
      imem_ack = 1'b0;
      chk($sformatf("v%0d wait%0d req", idx, w), {31'b0, imem_req}, 32'd1);
      chk($sformatf("v%0d wait%0d valid", idx, w), {31'b0, Instr_valid}, 32'd0);
      tick();
    end
    chk($sformatf("v%0d req", idx), {31'b0, imem_req}, 32'd1);
    chk($sformatf("v%0d addr", idx), imem_addr, v.pc);
    imem_ack   = 1'b1;
    imem_rdata = v.instr;
    sb.push_back('{pc: v.pc, instr: v.instr});
    tick();
    // EXEC: a stray ack with junk data must not disturb Instr
    imem_rdata = 32'hDEAD_BEEF;
    PCSrc      = v.pcsrc;
    Jump       = v.jump;
    SignImm    = v.simm;
    chk($sformatf("v%0d exec valid", idx), {31'b0, Instr_valid}, 32'd1);
    chk($sformatf("v%0d exec req", idx), {31'b0, imem_req}, 32'd0);
    if (Instr_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("v%0d instr", idx), Instr, e.instr);
      chk($sformatf("v%0d pc", idx), PC, e.pc);
      chk($sformatf("v%0d pcplus4", idx), PCPlus4, e.pc + 32'd4);
    end
    tick();
    imem_ack = 1'b0;
    chk($sformatf("v%0d post valid", idx), {31'b0, Instr_valid}, 32'd0);
    chk($sformatf("v%0d instr held", idx), Instr, v.instr);
    chk($sformatf("v%0d next pc", idx), PC, v.next_pc);
  endtask

  initial begin
    vecs[0]  = '{0, 32'h2002_0005, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{3, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    vecs[2]  = '{1, 32'h8C01_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_000C};
    vecs[3]  = '{0, 32'hAC01_0004, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C, 32'h0000_0010};
    vecs[4]  = '{2, 32'h1000_0003, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0010, 32'h0000_0020};
    vecs[5]  = '{0, 32'h1000_FFFB, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'h0000_0020, 32'h0000_0010};
    vecs[6]  = '{1, 32'h1000_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_0010};
    vecs[7]  = '{0, 32'h0800_0040, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0010, 32'h0000_0100};
    vecs[8]  = '{0, 32'h1000_0000, 1'b1, 1'b0, 32'h03FF_FFC0, 32'h0000_0100, 32'h1000_0004};
    vecs[9]  = '{2, 32'h0800_0040, 1'b1, 1'b1, 32'h0000_0007, 32'h1000_0004, 32'h1000_0100};
    vecs[10] = '{0, 32'h1000_0000, 1'b1, 1'b0, 32'h3BFF_FFBE, 32'h1000_0100, 32'hFFFF_FFFC};
    vecs[11] = '{1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[12] = '{0, 32'h0BFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0FFF_FFFC};
    vecs[13] = '{3, 32'h0800_0001, 1'b0, 1'b1, 32'h0000_0000, 32'h0FFF_FFFC, 32'h1000_0004};
    vecs[14] = '{0, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0100, 32'h1000_0004, 32'h1000_0008};

    // Reset held two cycles with a stray ack that must be ignored
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    tick();
    rst      = 1'b0;
    imem_ack = 1'b0;
    chk("rst pc", PC, 32'h0);
    chk("rst instr", Instr, 32'h0);
    chk("rst idle req", {31'b0, imem_req}, 32'd0);
    chk("rst valid", {31'b0, Instr_valid}, 32'd0);
    chk("rst err", {31'b0, fetch_err}, 32'd0);
    chk("rst pcplus4", PCPlus4, 32'h4);
    tick();
    chk("first fetch req", {31'b0, imem_req}, 32'd1);
    chk("first fetch addr", imem_addr, 32'h0);

    for (int i = 0; i < 15; i++) begin
      chk($sformatf("v%0d start pc", i), PC, vecs[i].pc);
      run_instr(i, vecs[i]);
    end
    chk("sb empty", sb.size(), 32'd0);

    // Reset in FETCH coinciding with ack: nothing captured, PC back to reset value
    chk("pre-rst req", {31'b0, imem_req}, 32'd1);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick();
    rst      = 1'b0;
    imem_ack = 1'b0;
    chk("midrst instr", Instr, 32'h0);
    chk("midrst pc", PC, 32'h0);
    chk("midrst valid", {31'b0, Instr_valid}, 32'd0);
    chk("midrst req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("midrst fetch valid", {31'b0, Instr_valid}, 32'd0);
    run_instr(100, '{0, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4});

    // Timeout: four FETCH cycles without ack, then ERROR
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("to wait%0d req", w), {31'b0, imem_req}, 32'd1);
      chk($sformatf("to wait%0d err", w), {31'b0, fetch_err}, 32'd0);
      tick();
    end
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("err%0d flag", w), {31'b0, fetch_err}, 32'd1);
      chk($sformatf("err%0d req", w), {31'b0, imem_req}, 32'd0);
      chk($sformatf("err%0d valid", w), {31'b0, Instr_valid}, 32'd0);
      chk($sformatf("err%0d pc", w), PC, 32'h4);
      chk($sformatf("err%0d instr", w), Instr, 32'hAAAA_5555);
      imem_ack   = 1'b1;
      imem_rdata = 32'h5555_AAAA;
      tick();
    end
    imem_ack = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("clr err", {31'b0, fetch_err}, 32'd0);
    chk("clr pc", PC, 32'h0);
    chk("clr instr", Instr, 32'h0);
    chk("clr req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("clr fetch req", {31'b0, imem_req}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
